// File: rtl/dclk_monitor_if.sv
// ----------------------------------------------------------------------------
// dclk_monitor_if
// Groups the sampled divided clock and the measurement results of the dclk
// monitor into one bundle.
//   dclk_i     divided, gated clock, sampled as data in the clk_i domain
//   period_o   last measured dclk period, in clk_i cycles
//   high_o     last measured dclk high time, in clk_i cycles
//   valid_o    one-cycle pulse when period_o/high_o update
//   change_o   one-cycle pulse with valid_o when the period differs
//   stopped_o  level, no dclk rising edge within the timeout window
// Modports:
//   master  the monitor: consumes dclk_i, drives the results
//   slave   the divider/consumer side: drives dclk_i, reads the results
// ----------------------------------------------------------------------------
interface dclk_monitor_if #(
  parameter int CNT_W = 16
);
  logic             dclk_i;
  logic [CNT_W-1:0] period_o;
  logic [CNT_W-1:0] high_o;
  logic             valid_o;
  logic             change_o;
  logic             stopped_o;

  modport master (
    input  dclk_i,
    output period_o,
    output high_o,
    output valid_o,
    output change_o,
    output stopped_o
  );

  modport slave (
    output dclk_i,
    input  period_o,
    input  high_o,
    input  valid_o,
    input  change_o,
    input  stopped_o
  );
endinterface

// File: rtl/dclk_monitor.sv
// ----------------------------------------------------------------------------
// dclk_monitor
// Measures period and high time of a divided, enable-gated clock that is
// sampled as ordinary data in the clk_i domain, flags period changes and
// flags when the divided clock stops.
// Ports:
//   clk_i  system clock, the only clock
//   rst_i  synchronous active-high reset
//   mon    dclk_monitor_if.master: dclk_i in, period/high/valid/change/stopped out
// Parameters:
//   CNT_W    width of the counters and the measurement outputs
//   TIMEOUT  clk_i cycles without a dclk rise before dclk is declared stopped
//            (3 .. 2**CNT_W-1, which also keeps the period counter from wrapping)
// ----------------------------------------------------------------------------
module dclk_monitor #(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 1000
) (
  input  logic           clk_i,
  input  logic           rst_i,
  dclk_monitor_if.master mon
);

  localparam logic [1:0] ST_IDLE = 2'd0;  // no reference edge yet
  localparam logic [1:0] ST_MEAS = 2'd1;  // counting since the last rise
  localparam logic [1:0] ST_STOP = 2'd2;  // timeout reached, waiting for dclk

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);

  logic [1:0]       r_state;
  logic             r_d1;
  logic             r_d2;
  logic [CNT_W-1:0] r_pcnt;
  logic [CNT_W-1:0] r_hcnt;
  logic             r_have_prev;
  logic [CNT_W-1:0] r_period;
  logic [CNT_W-1:0] r_high;
  logic             r_valid;
  logic             r_change;
  logic             r_stopped;

  logic             w_rise;

  // Rising edge of the registered dclk sample; a one-cycle glitch counts too.
  assign w_rise = r_d1 & ~r_d2;

  // Sampling pipeline, measurement counters, state machine and result registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= ST_IDLE;
      r_d1        <= 1'b0;
      r_d2        <= 1'b0;
      r_pcnt      <= '0;
      r_hcnt      <= '0;
      r_have_prev <= 1'b0;
      r_period    <= '0;
      r_high      <= '0;
      r_valid     <= 1'b0;
      r_change    <= 1'b0;
      r_stopped   <= 1'b0;
    end else begin
      r_d1     <= mon.dclk_i;
      r_d2     <= r_d1;
      r_valid  <= 1'b0;
      r_change <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          // First rise only establishes the reference; nothing is reported.
          if (w_rise) begin
            r_state <= ST_MEAS;
            r_pcnt  <= ONE_C;
            r_hcnt  <= ONE_C;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_MEAS: begin
          if (w_rise) begin
            r_period    <= r_pcnt;
            r_high      <= r_hcnt;
            r_valid     <= 1'b1;
            // r_period still holds the previous result here.
            r_change    <= r_have_prev && (r_pcnt != r_period);
            r_have_prev <= 1'b1;
            r_pcnt      <= ONE_C;
            r_hcnt      <= ONE_C;
          end else if (r_pcnt == TIMEOUT_C) begin
            // Counters hold; the next period after a stop is never a change.
            r_state     <= ST_STOP;
            r_stopped   <= 1'b1;
            r_have_prev <= 1'b0;
          end else begin
            r_pcnt <= r_pcnt + ONE_C;
            r_hcnt <= r_hcnt + CNT_W'(r_d1);
          end
        end
        ST_STOP: begin
          if (w_rise) begin
            r_state   <= ST_MEAS;
            r_stopped <= 1'b0;
            r_pcnt    <= ONE_C;
            r_hcnt    <= ONE_C;
          end else begin
            r_state <= ST_STOP;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_have_prev <= 1'b0;
          r_stopped   <= 1'b0;
        end
      endcase
    end
  end

  assign mon.period_o  = r_period;
  assign mon.high_o    = r_high;
  assign mon.valid_o   = r_valid;
  assign mon.change_o  = r_change;
  assign mon.stopped_o = r_stopped;

endmodule

// File: tb/tb_dclk_monitor.sv
// ----------------------------------------------------------------------------
// tb_dclk_monitor
// Drives dclk_i one clk_i cycle at a time from bit patterns. A reference model
// works from the driven bit stream: each dclk rise after a reference edge
// pushes the expected period/high/change and the clk_i edge on which valid_o
// must be seen; valid_o pulses pop and compare. stopped_o and the held results
// are compared whenever the expected or observed stopped level changes.
// ----------------------------------------------------------------------------
module tb_dclk_monitor;
  localparam int CNT_W   = 16;
  localparam int TIMEOUT = 1000;

  typedef struct {
    int period;
    int high;
    bit change;
    int due;
  } exp_t;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;

  dclk_monitor_if #(.CNT_W(CNT_W)) mon_if ();

  dclk_monitor #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .mon   (mon_if)
  );

  always #5 clk_i = ~clk_i;

  int   n_checks = 0;
  int   n_errors = 0;
  int   edge_cnt = 0;
  exp_t exp_q[$];

  // reference model state: 0 idle, 1 measuring, 2 stopped
  int   m_state       = 0;
  bit   m_prev_b      = 1'b0;
  int   m_last        = 0;
  int   m_ones        = 0;
  bit   m_have_prev   = 1'b0;
  int   m_prev_period = 0;
  bit   m_stop_next   = 1'b0;
  bit   m_stop_cur    = 1'b0;
  int   m_period_out  = 0;
  int   m_high_out    = 0;
  bit   obs_stop_prev = 1'b0;
  bit   exp_stop_prev = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, got, exp, edge_cnt);
    end
  endtask

  task automatic model_bit(input bit b);
    bit rise;
    int p;
    rise = b && !m_prev_b;
    if (rise) begin
      if (m_state == 1) begin
        p = edge_cnt - m_last;
        exp_q.push_back('{p, m_ones, (m_have_prev && (p != m_prev_period)), edge_cnt + 1});
        m_have_prev   = 1'b1;
        m_prev_period = p;
      end else begin
        m_state     = 1;
        m_stop_next = 1'b0;
      end
      m_last = edge_cnt;
      m_ones = 0;
    end else if (m_state == 1 && (edge_cnt - m_last) == TIMEOUT) begin
      m_state     = 2;
      m_stop_next = 1'b1;
      m_have_prev = 1'b0;
    end
    m_ones   = m_ones + int'(b);
    m_prev_b = b;
  endtask

  task automatic compare_outputs();
    exp_t e;
    if (mon_if.valid_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        check_val("spurious_valid", 32'(mon_if.valid_o), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check_val("valid_time", edge_cnt, e.due);
        check_val("period", 32'(mon_if.period_o), e.period);
        check_val("high", 32'(mon_if.high_o), e.high);
        check_val("change", 32'(mon_if.change_o), 32'(e.change));
        m_period_out = e.period;
        m_high_out   = e.high;
      end
    end else if (exp_q.size() > 0 && exp_q[0].due <= edge_cnt) begin
      e = exp_q.pop_front();
      check_val("valid_missing", 32'(mon_if.valid_o), 32'd1);
      m_period_out = e.period;
      m_high_out   = e.high;
    end
    if (mon_if.change_o === 1'b1 && mon_if.valid_o !== 1'b1)
      check_val("change_alone", 32'(mon_if.change_o), 32'd0);
    if (mon_if.stopped_o !== obs_stop_prev || m_stop_cur != exp_stop_prev) begin
      check_val("stopped", 32'(mon_if.stopped_o), 32'(m_stop_cur));
      check_val("hold_period", 32'(mon_if.period_o), m_period_out);
      check_val("hold_high", 32'(mon_if.high_o), m_high_out);
    end
    obs_stop_prev = (mon_if.stopped_o === 1'b1);
    exp_stop_prev = m_stop_cur;
  endtask

  // One clk_i cycle: drive on the falling edge, observe 1 time unit after the rising edge.
  task automatic step(input bit b, input bit rst);
    @(negedge clk_i);
    mon_if.dclk_i = b;
    rst_i         = rst;
    @(posedge clk_i);
    #1;
    edge_cnt++;
    if (rst) begin
      check_val("rst_period", 32'(mon_if.period_o), 32'd0);
      check_val("rst_high", 32'(mon_if.high_o), 32'd0);
      check_val("rst_valid", 32'(mon_if.valid_o), 32'd0);
      check_val("rst_change", 32'(mon_if.change_o), 32'd0);
      check_val("rst_stopped", 32'(mon_if.stopped_o), 32'd0);
      exp_q.delete();
      m_state       = 0;
      m_prev_b      = 1'b0;
      m_ones        = 0;
      m_have_prev   = 1'b0;
      m_stop_next   = 1'b0;
      m_stop_cur    = 1'b0;
      m_period_out  = 0;
      m_high_out    = 0;
      obs_stop_prev = 1'b0;
      exp_stop_prev = 1'b0;
    end else begin
      m_stop_cur = m_stop_next;
      compare_outputs();
      model_bit(b);
    end
  endtask

  task automatic run_div(input int n, input int h, input int cycles);
    for (int i = 0; i < cycles; i++) step(((i % n) < h), 1'b0);
  endtask

  initial begin
    logic [9:0] glitch_pat;
    mon_if.dclk_i = 1'b0;

    // reset, then divide-by-2
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    run_div(2, 1, 40);

    // divide-by-8 50% duty, then switch to divide-by-4
    run_div(8, 4, 64);
    run_div(4, 2, 32);

    // gate low for 1200 cycles, then re-enable
    repeat (1200) step(1'b0, 1'b0);
    run_div(4, 2, 32);

    // constant-high dclk straight out of reset
    step(1'b0, 1'b1);
    repeat (2000) step(1'b1, 1'b0);

    // divide-by-6 with a reset in the middle of a period
    step(1'b0, 1'b1);
    run_div(6, 3, 33);
    step(1'b1, 1'b1);
    run_div(6, 3, 36);

    // divide-by-10 50% duty with a one-cycle glitch in the low phase
    run_div(10, 5, 30);
    glitch_pat = 10'b0010011111;
    for (int i = 0; i < 10; i++) step(glitch_pat[i], 1'b0);
    run_div(10, 5, 40);

    // constant low out of reset never stops the monitor
    step(1'b0, 1'b1);
    repeat (1100) step(1'b0, 1'b0);
    check_val("idle_not_stopped", 32'(mon_if.stopped_o), 32'd0);
    check_val("queue_empty", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
